data_mem_unit: RTL and testbench

//  Multi-cycle data-memory stage of the MulCPU datapath. It sits between the ALU output register and the

---
 rtl/data_mem_unit_pkg.sv | 17 +
 rtl/data_mem_unit_byte_ram.sv | 22 ++
 rtl/data_mem_unit.sv | 163 ++++++++++++++++
 tb/tb_data_mem_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_unit_pkg.sv
// Shared memory-stage definitions (mem_defs): FSM states, access op codes, word geometry.
package data_mem_unit_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/data_mem_unit_byte_ram.sv
// Single-port DEPTH x 8 RAM: synchronous write, combinational read, contents not reset.
module byte_ram #(
    parameter int ADDR_W = 7
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [1 << ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle big-endian lw/sw stage, one byte per cycle over an internal byte RAM.
// Optional lb/sb support is enabled by defining BYTE_ACCESS_EN.
//
// state  | meaning
// IDLE   | waiting for mRD/mWR
// ACCESS | one byte per cycle; rejected requests spend one cycle here with no RAM access
// DONE   | Done pulse, AddrErr valid
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              mRD,
    input  logic              mWR,
    input  logic [DATA_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              ByteOp,
    output logic [DATA_W-1:0] DataOut,
    output logic              Busy,
    output logic              Done,
    output logic              AddrErr
);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic              byte_q, byte_d;
    logic              err_q, err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       shadow_q, shadow_d;
    logic [31:0]       dout_q, dout_d;

    logic              byte_sel;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic [1:0]        last_idx;
    logic [31:0]       assembled;

`ifdef BYTE_ACCESS_EN
    assign byte_sel = ByteOp;
`else
    logic unused_byteop;
    assign unused_byteop = ByteOp;
    assign byte_sel      = 1'b0;
`endif

    assign ram_addr = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
    assign last_idx = byte_q ? 2'd0 : 2'(WORD_BYTES - 1);

    byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        ram_wdata = din_q[7:0];
        assembled = shadow_q;
        if (!byte_q) begin
            case (cnt_q)
                2'd0:    ram_wdata = din_q[31:24];
                2'd1:    ram_wdata = din_q[23:16];
                2'd2:    ram_wdata = din_q[15:8];
                default: ram_wdata = din_q[7:0];
            endcase
        end
        case (cnt_q)
            2'd0:    assembled = {ram_rdata, shadow_q[23:0]};
            2'd1:    assembled = {shadow_q[31:24], ram_rdata, shadow_q[15:0]};
            2'd2:    assembled = {shadow_q[31:16], ram_rdata, shadow_q[7:0]};
            default: assembled = {shadow_q[31:8], ram_rdata};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        byte_d   = byte_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        din_d    = din_q;
        shadow_d = shadow_q;
        dout_d   = dout_q;
        ram_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mRD || mWR) begin
                    state_d = ACCESS;
                    op_d    = mWR ? OP_WR : OP_RD;
                    byte_d  = byte_sel;
                    addr_d  = DAddr[ADDR_W-1:0];
                    din_d   = DataIn[31:0];
                    cnt_d   = 2'd0;
                    err_d   = (mRD && mWR)
                            || (!byte_sel && (DAddr[1:0] != 2'b00))
                            || (DAddr[DATA_W-1:ADDR_W] != '0);
                end
            end
            ACCESS: begin
                if (!err_q) begin
                    if (op_q == OP_WR) begin
                        ram_we = 1'b1;
                    end else begin
                        shadow_d = assembled;
                    end
                end
                if (err_q || (cnt_q == last_idx)) begin
                    state_d = DONE;
                    if (!err_q && (op_q == OP_RD)) begin
                        dout_d = byte_q ? {{24{ram_rdata[7]}}, ram_rdata} : assembled;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            op_q     <= OP_RD;
            byte_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            din_q    <= 32'h0;
            shadow_q <= 32'h0;
            dout_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            byte_q   <= byte_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
        end
    end

    assign DataOut = DATA_W'(dout_q);
    assign Busy    = (state_q != IDLE);
    assign Done    = (state_q == DONE);
    assign AddrErr = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: stimulus pushes expected responses, a negedge monitor checks each Done.
module tb_data_mem_unit;

    localparam int ADDR_W = 7;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        mRD = 1'b0;
    logic        mWR = 1'b0;
    logic        ByteOp = 1'b0;
    logic [31:0] DAddr = 32'h0;
    logic [31:0] DataIn = 32'h0;
    logic [31:0] DataOut;
    logic        Busy;
    logic        Done;
    logic        AddrErr;

    data_mem_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .mRD     (mRD),
        .mWR     (mWR),
        .DAddr   (DAddr),
        .DataIn  (DataIn),
        .ByteOp  (ByteOp),
        .DataOut (DataOut),
        .Busy    (Busy),
        .Done    (Done),
        .AddrErr (AddrErr)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] dout;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (Reset && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 expected no pending access (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_err"}, 32'(AddrErr), 32'(mon_e.err));
                chk({mon_e.name, "_dout"}, DataOut, mon_e.dout);
                chk({mon_e.name, "_lat"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (Busy && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        chk({name, "_idle_timeout"}, 32'(Busy), 32'd0);
    endtask

    task automatic accept(input string name, input bit rd, input bit wr, input bit bo,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit exp_err, input int lat, input logic [31:0] exp_dout,
                          input bit track);
        mRD = rd; mWR = wr; ByteOp = bo; DAddr = a; DataIn = d;
        @(posedge CLK); #1;
        if (track) sb.push_back('{name, exp_err, exp_dout, cyc, lat});
        mRD = 1'b0; mWR = 1'b0; ByteOp = 1'b0;
        DAddr = 32'hDEAD_BEEF; DataIn = 32'h0BAD_F00D;
    endtask

    task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d,
                      input bit bo, input int lat);
        accept(name, 1'b0, 1'b1, bo, a, d, 1'b0, lat, last_rd, 1'b1);
        wait_idle(name);
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp,
                      input bit bo, input int lat);
        last_rd = exp;
        accept(name, 1'b1, 1'b0, bo, a, 32'h0, 1'b0, lat, exp, 1'b1);
        wait_idle(name);
    endtask

    task automatic bad(input string name, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
        accept(name, r, w, 1'b0, a, d, 1'b1, 1, last_rd, 1'b1);
        wait_idle(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b1;
        @(negedge CLK);
        chk("rst_dout", DataOut, 32'h0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(AddrErr), 32'd0);
        @(posedge CLK); #1;

        wr("wr08", 32'h08, 32'h1234_5678, 1'b0, 4);
        rd("rd08", 32'h08, 32'h1234_5678, 1'b0, 4);
        wr("wr00", 32'h00, 32'hCAFE_F00D, 1'b0, 4);
        wr("wr7c", 32'h7C, 32'h0F1E_2D3C, 1'b0, 4);
        rd("rd7c", 32'h7C, 32'h0F1E_2D3C, 1'b0, 4);

        bad("err_misalign_rd", 1'b1, 1'b0, 32'h06, 32'h0);
        bad("err_range_wr", 1'b0, 1'b1, 32'h80, 32'h5555_5555);
        rd("rd00_untouched", 32'h00, 32'hCAFE_F00D, 1'b0, 4);
        bad("err_both", 1'b1, 1'b1, 32'h08, 32'h0);
        bad("err_high_addr", 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        bad("err_misalign_wr", 1'b0, 1'b1, 32'h02, 32'h7777_7777);
        rd("rd08_again", 32'h08, 32'h1234_5678, 1'b0, 4);

        // read request pulsed while the write is busy must be dropped
        accept("wr10_busy", 1'b0, 1'b1, 1'b0, 32'h10, 32'h9ABC_DEF0, 1'b0, 4, last_rd, 1'b1);
        @(posedge CLK); #1;
        mRD = 1'b1; DAddr = 32'h08;
        @(posedge CLK); #1;
        mRD = 1'b0;
        wait_idle("wr10_busy");
        rd("rd10", 32'h10, 32'h9ABC_DEF0, 1'b0, 4);

        // reset after the second byte edge of a write
        wr("wr20_pre", 32'h20, 32'h1122_3344, 1'b0, 4);
        accept("wr20_abort", 1'b0, 1'b1, 1'b0, 32'h20, 32'hAABB_CCDD, 1'b0, 4, last_rd, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        #1;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_dout", DataOut, 32'h0);
        last_rd = 32'h0;
        @(posedge CLK); @(posedge CLK); #1;
        Reset = 1'b1;
        @(posedge CLK); #1;
        rd("rd20_partial", 32'h20, 32'hAABB_3344, 1'b0, 4);

`ifdef BYTE_ACCESS_EN
        wr("sb31", 32'h31, 32'h0000_0080, 1'b1, 1);
        rd("lb31", 32'h31, 32'hFFFF_FF80, 1'b1, 1);
        rd("lb21", 32'h21, 32'hFFFF_FFBB, 1'b1, 1);
        wr("sb33", 32'h33, 32'h1234_567F, 1'b1, 1);
        rd("lb33", 32'h33, 32'h0000_007F, 1'b1, 1);
        rd("rd30", 32'h30, 32'h0080_007F & 32'h00FF_00FF | (32'h0 & 32'hFF00_FF00), 1'b0, 4);
`else
        wr("wr30_byteop_ignored", 32'h30, 32'h0000_0080, 1'b1, 4);
        rd("rd30_byteop_ignored", 32'h30, 32'h0000_0080, 1'b1, 4);
        accept("err31_byteop_ignored", 1'b1, 1'b0, 1'b1, 32'h31, 32'h0, 1'b1, 1, last_rd, 1'b1);
        wait_idle("err31_byteop_ignored");
`endif

        repeat (3) @(posedge CLK);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
